truth_table_extractor: RTL
==========================

Name: truth_table_extractor

Overview:
- Sequential verifier for the team's minimized combinational logic. Drives every input combination into a function-under-test (FUT) and captures each response into a truth table.
- After the sweep, streams out the minterm list (indices where the output is 1) per function over a valid/ready interface, with per-function minterm counts.
- Sits in the test/bring-up path beside the combinational blocks. It is the read-back direction for minimized SOP logic: expression in, minterm list out.

Parameters:
- N_IN, 4, number of FUT inputs; sweep covers 2**N_IN combinations.
- NUM_FN, 2, number of FUT output functions captured in parallel.
- SETTLE, 1, cycles each stimulus is held before sampling (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin sweep; accepted only in IDLE
- busy  output  1  high from accepted start until done
- done  output  1  one-cycle pulse at completion
- stim  output  N_IN  registered stimulus to FUT; stim[N_IN-1] is the MSB input (a/w), stim[0] is the LSB input (d/z)
- resp  input  NUM_FN  FUT outputs; resp[k] is function k
- tt  output  NUM_FN*2**N_IN  captured table; bit k*2**N_IN+i = function k at index i
- mt_count  output  NUM_FN*(N_IN+1)  ones count per function, field k at [k*(N_IN+1)+:N_IN+1]
- mt_valid  output  1  minterm available
- mt_ready  input  1  sink accepts minterm
- mt_fn  output  max(1,clog2(NUM_FN))  function index of the current minterm
- mt_index  output  N_IN  minterm index
- mt_last  output  1  current minterm is the last 1 of its function

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, stim=0, tt=0, mt_count=0, mt_valid=0, mt_fn=0, mt_index=0, mt_last=0. Assertion mid-sweep or mid-emit aborts immediately. No output pulse on reset release.
- States: IDLE, DRIVE, EMIT, FIN.
- IDLE: start=1 -> clear tt and mt_count; idx=0; stim<=0; settle=0; busy<=1; go to DRIVE.
- DRIVE: stim holds idx. Increment settle each cycle. On the cycle where settle==SETTLE-1, sample every resp[k] into tt bit (k,idx) and add it to count k.
  - If idx==2**N_IN-1: go to EMIT with fn=0, scan=0.
  - Else: idx++, stim<=idx+1, settle=0.
  - Sweep length is exactly SETTLE*2**N_IN cycles.
- EMIT: scan walks (fn, scan) in order: fn ascending, index ascending.
  - A zero bit costs one cycle and is skipped.
  - On a one bit, register mt_valid=1, mt_fn, mt_index, mt_last. Hold all of them stable until mt_valid&&mt_ready, then advance scan.
  - mt_valid must never drop without a handshake.
  - mt_last=1 iff no higher index of the same fn is 1.
  - After fn=NUM_FN-1, index 2**N_IN-1 is consumed or skipped: go to FIN.
- FIN: done=1 for one cycle, busy<=0, go to IDLE.
- tt and mt_count hold their values until the next accepted start.
- start while busy is ignored; no queuing.
- All-zero function: emits nothing and mt_count=0. All-ones function: emits 2**N_IN minterms and mt_count=2**N_IN (which is why the field is N_IN+1 bits wide).
- mt_ready held low indefinitely: block stalls in EMIT with outputs stable.
- Backpressure never alters tt or mt_count.

Test Plan:
- Reset mid-sweep: pulse rst_n low after 5 DRIVE cycles -> busy=0, stim=0, tt=0 asynchronously; a subsequent start runs a full, correct sweep.
- FUT = team f1 (b'd'+a'bd+abc'), mt_ready=1, SETTLE=1 -> tt[15:0]=0x35A5; count0=8; minterms 0,2,5,7,8,10,12,13 with mt_last only on 13; done exactly 16 cycles after start acceptance plus the emit scan.
- FUT = team f2 (y'z+xy+wy) on function 1 -> tt[31:16]=0xEEE2; count1=10; minterms 1,5,6,7,9,10,11,13,14,15, mt_fn=1, mt_last on 15.
- Backpressure: toggle mt_ready randomly during EMIT -> mt_fn, mt_index and mt_last stable while valid&&!ready; identical minterm sequence; no drops or duplicates.
- Constant FUT: resp=0 -> no mt_valid, counts 0, done fires. resp=1 -> 16 minterms per function, counts 16.
- SETTLE=3 with start pulsed during busy -> each stim held 3 cycles, sweep 48 cycles, extra start ignored, single done pulse.

Source files
------------

// File: rtl/truth_table_extractor.sv
// Sweeps every input combination through a combinational function-under-test,
// captures its truth table, then streams the minterm list per function.
module truth_table_extractor #(
    parameter int N_IN   = 4,
    parameter int NUM_FN = 2,
    parameter int SETTLE = 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    output logic                                      busy,
    output logic                                      done,
    output logic [N_IN-1:0]                           stim,
    input  logic [NUM_FN-1:0]                         resp,
    output logic [NUM_FN*(2**N_IN)-1:0]               tt,
    output logic [NUM_FN*(N_IN+1)-1:0]                mt_count,
    output logic                                      mt_valid,
    input  logic                                      mt_ready,
    output logic [((NUM_FN > 1) ? $clog2(NUM_FN) : 1)-1:0] mt_fn,
    output logic [N_IN-1:0]                           mt_index,
    output logic                                      mt_last
);

    localparam int DEPTH = 2**N_IN;
    localparam int FW    = (NUM_FN > 1) ? $clog2(NUM_FN) : 1;
    localparam int CW    = N_IN + 1;
    localparam int SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_EMIT, S_FIN} state_t;

    state_t                    state_q, state_d;
    logic [N_IN-1:0]           idx_q, idx_d;
    logic [SW-1:0]             settle_q, settle_d;
    logic [NUM_FN*DEPTH-1:0]   tt_q, tt_d;
    logic [NUM_FN*CW-1:0]      cnt_q, cnt_d;
    logic [FW-1:0]             fn_q, fn_d;
    logic [N_IN-1:0]           scan_q, scan_d;
    logic                      valid_q, valid_d;
    logic [FW-1:0]             mt_fn_q, mt_fn_d;
    logic [N_IN-1:0]           mt_index_q, mt_index_d;
    logic                      mt_last_q, mt_last_d;

    logic [DEPTH-1:0]          row;
    logic                      cur_bit;
    logic                      more_ones;
    logic                      advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            settle_q   <= '0;
            tt_q       <= '0;
            cnt_q      <= '0;
            fn_q       <= '0;
            scan_q     <= '0;
            valid_q    <= 1'b0;
            mt_fn_q    <= '0;
            mt_index_q <= '0;
            mt_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            settle_q   <= settle_d;
            tt_q       <= tt_d;
            cnt_q      <= cnt_d;
            fn_q       <= fn_d;
            scan_q     <= scan_d;
            valid_q    <= valid_d;
            mt_fn_q    <= mt_fn_d;
            mt_index_q <= mt_index_d;
            mt_last_q  <= mt_last_d;
        end
    end

    // Minterm stream: valid/ready. Once mt_valid rises, mt_fn/mt_index/mt_last
    // stay frozen and valid stays high until a cycle with mt_valid && mt_ready.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        settle_d   = settle_q;
        tt_d       = tt_q;
        cnt_d      = cnt_q;
        fn_d       = fn_q;
        scan_d     = scan_q;
        valid_d    = valid_q;
        mt_fn_d    = mt_fn_q;
        mt_index_d = mt_index_q;
        mt_last_d  = mt_last_q;
        advance    = 1'b0;

        row = '0;
        for (int k = 0; k < NUM_FN; k++) begin
            if (fn_q == FW'(k)) row = tt_q[k*DEPTH +: DEPTH];
        end
        cur_bit   = row[scan_q];
        more_ones = |((row >> scan_q) >> 1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_DRIVE;
                    tt_d     = '0;
                    cnt_d    = '0;
                    idx_d    = '0;
                    settle_d = '0;
                end
            end
            S_DRIVE: begin
                settle_d = settle_q + SW'(1);
                if (settle_q == SW'(SETTLE - 1)) begin
                    for (int k = 0; k < NUM_FN; k++) begin
                        tt_d[k*DEPTH + int'(idx_q)] = resp[k];
                        cnt_d[k*CW +: CW] = cnt_q[k*CW +: CW] + CW'(resp[k]);
                    end
                    if (&idx_q) begin
                        state_d = S_EMIT;
                        fn_d    = '0;
                        scan_d  = '0;
                    end else begin
                        idx_d    = idx_q + N_IN'(1);
                        settle_d = '0;
                    end
                end
            end
            S_EMIT: begin
                if (valid_q) begin
                    if (mt_ready) begin
                        valid_d = 1'b0;
                        advance = 1'b1;
                    end
                end else if (cur_bit) begin
                    valid_d    = 1'b1;
                    mt_fn_d    = fn_q;
                    mt_index_d = scan_q;
                    mt_last_d  = ~more_ones;
                end else begin
                    advance = 1'b1;
                end

                // Scan order is function-major, index ascending.
                if (advance) begin
                    if (&scan_q) begin
                        if (fn_q == FW'(NUM_FN - 1)) begin
                            state_d = S_FIN;
                        end else begin
                            fn_d   = fn_q + FW'(1);
                            scan_d = '0;
                        end
                    end else begin
                        scan_d = scan_q + N_IN'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_FIN);
        stim     = idx_q;
        tt       = tt_q;
        mt_count = cnt_q;
        mt_valid = valid_q;
        mt_fn    = mt_fn_q;
        mt_index = mt_index_q;
        mt_last  = mt_last_q;
    end

endmodule
